// File: rtl/viterbi_decoder_param.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_decoder_param
// Brief    : Rate-1/2, K=3 (G0=7, G1=5) Viterbi decoder. Survivors are kept
//            by register exchange. Framed operation with an end-of-frame
//            flush and a ready handshake.
//            Optional feature macro: VD_SOFT_DECISION_EN (soft-decision
//            input of 2*SOFT_W bits instead of 2 hard bits).
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_decoder_param #(
  parameter int TB_DEPTH = 8,
  parameter int PM_W     = 6,
  parameter int SOFT_W   = 3
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic                i_last,
`ifdef VD_SOFT_DECISION_EN
  input  logic [2*SOFT_W-1:0] i_data,
`else
  input  logic [1:0]          i_data,
`endif
  output logic                o_ready,
  output logic                o_decision,
  output logic                o_valid,
  output logic                o_last
);

`ifdef VD_SOFT_DECISION_EN
  localparam int DW   = 2 * SOFT_W;
  localparam int BM_W = SOFT_W + 1;
  localparam logic [SOFT_W-1:0] C_SOFT_MAX = {SOFT_W{1'b1}};
`else
  localparam int DW   = 2;
  localparam int BM_W = 2;
`endif
  localparam int CNT_W = $clog2(TB_DEPTH + 1);
  localparam int IDX_W = $clog2(TB_DEPTH);
  localparam logic [PM_W-1:0]  C_PM_MAX = {PM_W{1'b1}};
  localparam logic [CNT_W-1:0] C_DEPTH  = CNT_W'(TB_DEPTH);

  // Elaboration-time parameter legality checks
  if (TB_DEPTH < 2 || TB_DEPTH > 64) begin : g_chk_depth
    $error("viterbi_decoder_param: TB_DEPTH must be in 2..64");
  end
`ifdef VD_SOFT_DECISION_EN
  if (PM_W < SOFT_W + 4) begin : g_chk_pm
    $error("viterbi_decoder_param: PM_W must be >= SOFT_W+4");
  end
`else
  if (PM_W < 2 || SOFT_W < 1) begin : g_chk_pm
    $error("viterbi_decoder_param: PM_W must be >= 2");
  end
`endif

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t              state_q;
  logic [PM_W-1:0]     pm_q   [4];
  logic [TB_DEPTH-1:0] surv_q [4];
  logic [CNT_W-1:0]    n_q;
  logic [CNT_W-1:0]    n_d;
  logic [IDX_W-1:0]    pos_q;
  logic [1:0]          best_q;
  logic                ready_q, valid_q, dec_q, last_q;

  logic [PM_W-1:0]     cand0    [4];
  logic [PM_W-1:0]     cand1    [4];
  logic [PM_W-1:0]     cand_raw [4];
  logic [PM_W-1:0]     cand_min;
  logic [PM_W-1:0]     acs_pm   [4];
  logic [TB_DEPTH-1:0] acs_surv [4];
  logic [1:0]          acs_best;

  // Distance between the received symbol and the expected pair {e0,e1}
  function automatic logic [BM_W-1:0] branch_metric(input logic [DW-1:0] d,
                                                    input logic e0, input logic e1);
`ifdef VD_SOFT_DECISION_EN
    logic [SOFT_W-1:0] c0;
    logic [SOFT_W-1:0] c1;
    c0 = e0 ? (C_SOFT_MAX - d[2*SOFT_W-1:SOFT_W]) : d[2*SOFT_W-1:SOFT_W];
    c1 = e1 ? (C_SOFT_MAX - d[SOFT_W-1:0])        : d[SOFT_W-1:0];
    return BM_W'(c0) + BM_W'(c1);
`else
    return BM_W'(d[1] ^ e0) + BM_W'(d[0] ^ e1);
`endif
  endfunction

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [BM_W-1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + (PM_W+1)'(b);
    return s[PM_W] ? C_PM_MAX : s[PM_W-1:0];
  endfunction

  // Add-compare-select, survivor exchange, normalisation and best-state search
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      // ns[1] is the input bit; predecessors are {ns[0],0} and {ns[0],1}
      cand0[ns] = sat_add(pm_q[2*(ns%2)],
                          branch_metric(i_data, ns[1] ^ ns[0], ns[1]));
      cand1[ns] = sat_add(pm_q[2*(ns%2)+1],
                          branch_metric(i_data, ~(ns[1] ^ ns[0]), ~ns[1]));
      if (cand1[ns] < cand0[ns]) begin
        cand_raw[ns] = cand1[ns];
        acs_surv[ns] = {surv_q[2*(ns%2)+1][TB_DEPTH-2:0], ns[1]};
      end else begin
        cand_raw[ns] = cand0[ns];
        acs_surv[ns] = {surv_q[2*(ns%2)][TB_DEPTH-2:0], ns[1]};
      end
    end
    cand_min = cand_raw[0];
    for (int s = 1; s < 4; s++) begin
      if (cand_raw[s] < cand_min) cand_min = cand_raw[s];
    end
    acs_best = 2'd3;
    for (int s = 3; s >= 0; s--) begin
      if (cand_raw[s] == cand_min) acs_best = 2'(s);
    end
    for (int s = 0; s < 4; s++) begin
      acs_pm[s] = cand_raw[s] - cand_min;
    end
  end

  assign n_d = (n_q == C_DEPTH) ? n_q : n_q + CNT_W'(1);

  // Frame FSM: RUN accepts and decodes symbols, FLUSH drains the latched survivor
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      for (int s = 0; s < 4; s++) begin
        pm_q[s]   <= (s == 0) ? '0 : C_PM_MAX;
        surv_q[s] <= '0;
      end
      n_q     <= '0;
      pos_q   <= '0;
      best_q  <= 2'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dec_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (i_valid && ready_q) begin
            pm_q   <= acs_pm;
            surv_q <= acs_surv;
            n_q    <= n_d;
            if (i_last) begin
              pos_q   <= IDX_W'(n_d - CNT_W'(1));
              best_q  <= acs_best;
              ready_q <= 1'b0;
              state_q <= ST_FLUSH;
            end else if (n_d == C_DEPTH) begin
              valid_q <= 1'b1;
              dec_q   <= acs_surv[acs_best][TB_DEPTH-1];
            end
          end
        end
        ST_FLUSH: begin
          valid_q <= 1'b1;
          dec_q   <= surv_q[best_q][pos_q];
          if (pos_q == '0) begin
            last_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_RUN;
            for (int s = 0; s < 4; s++) begin
              pm_q[s]   <= (s == 0) ? '0 : C_PM_MAX;
              surv_q[s] <= '0;
            end
            n_q <= '0;
          end else begin
            pos_q <= pos_q - IDX_W'(1);
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_decision = dec_q;
  assign o_last     = last_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_decoder_param
// Brief    : Scoreboard bench for viterbi_decoder_param (TB_DEPTH=8).
//            Soft-decision vectors are added when VD_SOFT_DECISION_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_decoder_param;
  localparam int TB_DEPTH = 8;
  localparam int PM_W     = 6;
  localparam int SOFT_W   = 3;
`ifdef VD_SOFT_DECISION_EN
  localparam int DW = 2 * SOFT_W;
`else
  localparam int DW = 2;
`endif

  logic          i_clk, i_rst_n, i_valid, i_last;
  logic [DW-1:0] i_data;
  logic          o_ready, o_decision, o_valid, o_last;

  typedef struct packed { logic dec; logic last; } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] fsym[$];
  logic          fbit[$];
  int            checks = 0;
  int            errors = 0;

  viterbi_decoder_param #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W), .SOFT_W(SOFT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_last(i_last),
    .i_data(i_data), .o_ready(o_ready), .o_decision(o_decision),
    .o_valid(o_valid), .o_last(o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pop one expected bit per DUT output pulse
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n === 1'b1 && o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        check("decision", o_decision, e.dec);
        check("last_flag", o_last, e.last);
      end
    end
  end

  function automatic logic [DW-1:0] map(input logic [1:0] s);
`ifdef VD_SOFT_DECISION_EN
    logic [SOFT_W-1:0] hi;
    logic [SOFT_W-1:0] lo;
    hi = s[1] ? '1 : '0;
    lo = s[0] ? '1 : '0;
    return {hi, lo};
`else
    return s;
`endif
  endfunction

  // Load an 8-symbol frame, first symbol in the most significant position
  task automatic load8(input logic [15:0] syms, input logic [7:0] bits);
    fsym.delete();
    fbit.delete();
    for (int i = 7; i >= 0; i--) begin
      fsym.push_back(map(syms[2*i +: 2]));
      fbit.push_back(bits[i]);
    end
  endtask

  // Encode a 20-bit frame (first bit in the MSB) starting from state 0
  task automatic load_encoded20(input logic [19:0] bits);
    logic [1:0] st;
    logic       u;
    st = 2'b00;
    fsym.delete();
    fbit.delete();
    for (int i = 19; i >= 0; i--) begin
      u = bits[i];
      fbit.push_back(u);
      fsym.push_back(map({u ^ st[1] ^ st[0], u ^ st[0]}));
      st = {u, st[1]};
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int guard;
    guard = 0;
    while (o_ready !== 1'b1 && guard < 64) begin
      @(negedge i_clk);
      guard++;
    end
    check("ready_before_send", o_ready, 1);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic run_frame(input int gap, input logic chk_lat);
    exp_t e;
    int   n;
    n = fsym.size();
    for (int i = 0; i < n; i++) begin
      e.dec  = fbit[i];
      e.last = (i == n - 1);
      sb.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      send(fsym[i], i == n - 1);
      if (chk_lat) check("stream_valid_timing", o_valid,
                         32'((i + 1 >= TB_DEPTH) && (i != n - 1)));
      if (i != n - 1) repeat (gap) @(negedge i_clk);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge i_clk);
      guard++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = '0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_decision", o_decision, 0);
    check("rst_last", o_last, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Alternating pattern; o_ready must stay low for TB_DEPTH cycles of flush
    load8(16'b11_10_00_10_00_10_00_10, 8'b1010_1010);
    run_frame(0, 1'b0);
    lowc = 0;
    while (o_ready === 1'b0 && lowc < 64) begin
      lowc++;
      @(negedge i_clk);
    end
    check("flush_ready_low_cycles", lowc, TB_DEPTH);
    drain();

    // Second pattern, clean
    load8(16'b00_00_11_10_00_10_11_11, 8'b0010_1001);
    run_frame(0, 1'b0);
    drain();

    // Same pattern with a single channel error on symbol 3
    load8(16'b00_00_01_10_00_10_11_11, 8'b0010_1001);
    run_frame(0, 1'b0);
    drain();

    // 20-symbol frame: streaming output after the 8th symbol, then flush
    load_encoded20(20'b1011_0011_1000_1011_0100);
    run_frame(0, 1'b1);
    drain();

    // 3-cycle input stalls between symbols
    load8(16'b00_00_11_10_00_10_11_11, 8'b0010_1001);
    run_frame(3, 1'b0);
    drain();

    // Symbols offered during flush are dropped
    load8(16'b11_10_00_10_00_10_00_10, 8'b1010_1010);
    run_frame(0, 1'b0);
    i_valid = 1'b1;
    i_data  = map(2'b11);
    i_last  = 1'b1;
    repeat (4) @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    drain();
    load8(16'b00_00_11_10_00_10_11_11, 8'b0010_1001);
    run_frame(0, 1'b0);
    drain();

    // Asynchronous reset in the middle of a flush
    load8(16'b11_10_00_10_00_10_00_10, 8'b1010_1010);
    run_frame(0, 1'b0);
    repeat (3) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("midflush_rst_valid", o_valid, 0);
    check("midflush_rst_ready", o_ready, 1);
    check("midflush_rst_last", o_last, 0);
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    load8(16'b00_00_11_10_00_10_11_11, 8'b0010_1001);
    run_frame(0, 1'b0);
    drain();

`ifdef VD_SOFT_DECISION_EN
    // Soft input: second symbol weakened to (7,4)
    load8(16'b11_10_00_10_00_10_00_10, 8'b1010_1010);
    fsym[1] = {3'd7, 3'd4};
    run_frame(0, 1'b0);
    drain();
`endif

    repeat (4) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/viterbi_decoder_param.md
# viterbi_decoder_param

Parametrised rate-1/2, constraint-length-3 Viterbi decoder, generators G0 = 7 (111) and G1 = 5 (101). It is the next-generation drop-in for the channel-decoder slot. Over the current decoder it adds:
- configurable traceback depth;
- framed operation with an end-of-frame flush;
- a ready handshake;
- optional soft-decision inputs.

It decodes a stream of encoder symbol pairs into one data bit per symbol, using register-exchange survivors.

## Interface
- TB_DEPTH, 8, survivor length in symbols; legal 2..64.
- PM_W, 6, path-metric width; must be ≥ SOFT_W+4 when soft decision is enabled.
- SOFT_W, 3, bits per soft symbol component; used only with VD_SOFT_DECISION_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  symbol qualifier; a symbol is accepted on an edge with i_valid & o_ready.
- i_last  in  1  marks the accepted symbol as the final symbol of the frame; ignored unless the symbol is accepted.
- i_data  in  2 (hard) / 2*SOFT_W (soft)  symbol. The high half is the G0 output and the low half is the G1 output.
- o_ready  out  1  high when a symbol can be accepted; low during flush.
- o_decision  out  1  decoded bit.
- o_valid  out  1  o_decision qualifier; one-cycle pulse per bit; no backpressure.
- o_last  out  1  high with the final decoded bit of the frame.

## Operation
- Trellis:
  - State s = {u[t-1], u[t-2]}; input u moves the decoder to next state {u, s[1]}.
  - Expected outputs: g0 = u^s[1]^s[0], g1 = u^s[0].
- Branch metric:
  - Hard decision: Hamming distance between i_data and {g0,g1}, range 0..2.
  - Soft decision: per component, r if the expected bit is 0, else (2^SOFT_W-1)-r; the two components are summed.
- ACS:
  - Predecessors of next state ns are {ns[0],0} and {ns[0],1}.
  - Candidate metric = PM + BM, saturating at 2^PM_W-1.
  - The smaller candidate wins; on a tie the predecessor with the lower index wins.
  - Survivor update: surv[ns] = {surv[pred][TB_DEPTH-2:0], ns[1]}.
- Normalisation: after each ACS, the minimum new PM is subtracted from all four, so min PM is always 0.
- Best state: lowest-index state whose PM is 0.
- Frame start: PM = {0, max, max, max} (start in state 0); surv = 0; symbol count n = 0.
- FSM:
  - RUN: while o_ready=1, each accepted symbol performs ACS. The count n saturates at TB_DEPTH.
    - Non-last symbol with post-increment n = TB_DEPTH: emit new surv[best][TB_DEPTH-1].
    - Last symbol: no emit. Set R = min(frame length, TB_DEPTH), latch best state, go to FLUSH.
  - FLUSH: survivors are frozen. Emit bits at positions R-1 down to 0 of the latched best state, one per cycle. o_last is set with position 0. On that same edge, reinitialise the frame state and return to RUN.
- A frame of N symbols yields exactly N decoded bits in input order.
- i_valid low in RUN is a stall: no ACS, no output, state held.
- i_valid during FLUSH: the symbol is dropped with no state change. The source must wait for o_ready.

## Timing
- Reset values (asynchronous):
  - o_ready=1, o_valid=0, o_decision=0, o_last=0.
  - FSM in RUN, frame state initialised.
- All outputs are registered.
- Streaming output: o_valid rises after the edge that accepts symbol k ≥ TB_DEPTH, not last. It carries decoded bit k-TB_DEPTH+1.
- Flush (last symbol accepted at edge E0):
  - o_ready is low after E0.
  - Flush bits appear after edges E1..ER; o_last is set after ER.
  - o_ready returns high after ER; a new frame can be accepted at edge ER+1.
- Single-symbol frame: R=1; one bit after E1, carrying o_last.
- Reset asserted mid-frame or mid-flush: outputs go to reset values immediately; any partial frame is discarded.

## Configuration
- VD_SOFT_DECISION_EN:
  - Defined: i_data is 2*SOFT_W bits, unsigned confidence (0 = strong 0, 2^SOFT_W-1 = strong 1); soft branch metric.
  - Undefined: i_data is 2 bits; Hamming branch metric; SOFT_W unused.
  - The FSM, latency and handshake are identical in both builds.

## Test plan
- Hard, TB_DEPTH=8:
  - Stimulus: 11,10,00,10,00,10,00,10, i_last on the 8th.
  - Required: o_ready low for 8 cycles; 8 o_valid pulses carrying 1,0,1,0,1,0,1,0; o_last on the 8th pulse.
- Hard:
  - Stimulus: 00,00,11,10,00,10,11,11, i_last on the 8th.
  - Required: 0,0,1,0,1,0,0,1.
- Single-error correction: the same frame with the 3rd symbol as 01.
  - Required: still 0,0,1,0,1,0,0,1.
- 20-symbol frame of encoded 1011001110001011010 plus a trailing 0, TB_DEPTH=8:
  - First o_valid after the 8th acceptance.
  - 12 streaming bits, then 8 flush bits; all 20 correct; o_last only on bit 20.
- Stalls, drops and reset:
  - 3-cycle i_valid gaps mid-frame: output is unchanged apart from delay.
  - i_valid=1 during flush: ignored.
  - i_rst_n pulsed mid-flush: o_valid=0 and o_ready=1 immediately; the next frame decodes correctly.
- VD_SOFT_DECISION_EN, SOFT_W=3:
  - Stimulus: test 1 mapped 0→0 and 1→7, except the 2nd symbol given as (7,4).
  - Required: 1,0,1,0,1,0,1,0.
